// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scanner.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DEAD = 2'd1,
        ST_ON   = 2'd2
    } state_t;

    // All-ones digit-enable mask for n digits (n <= 8), i.e. every digit dark.
    function automatic logic [7:0] digit_off(input int n);
        return 8'hFF >> (8 - n);
    endfunction

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Window timer: up-counter with clear and load; tc flags count == tc_val.
module seg_scan_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] tc_val,
    output logic         tc
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == tc_val);

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexes an N-digit hex value onto a registered 7-seg decoder with dead time between digits.
// Optional leading-zero blanking under SEG_SCAN_LZB_EN; new values latch only on frame boundaries.
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int DEAD_CYCLES = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [4*NUM_DIGITS-1:0] VALUE,
    input  logic                    LOAD,
    input  logic                    ENABLE,
    output logic [3:0]              D,
    output logic [NUM_DIGITS-1:0]   DIGIT,
    output logic                    FRAME_DONE
);
    localparam int IW   = idx_width(NUM_DIGITS);
    localparam int TMAX = (SCAN_DIV > DEAD_CYCLES) ? SCAN_DIV : DEAD_CYCLES;
    localparam int TW   = $clog2(TMAX);
    localparam logic [7:0]            OFF8      = digit_off(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] DIGIT_OFF = OFF8[NUM_DIGITS-1:0];
    localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [3:0]              nib_q, nib_d;
    logic [NUM_DIGITS-1:0]   digit_q, digit_d;
    logic                    frame_done_q, frame_done_d;

    logic                    tmr_clr;
    logic                    tmr_tc;
    logic [TW-1:0]           tmr_tc_val;
    logic                    frame_wrap;
    logic                    xfer;
    logic                    lzb_blank;

    assign tmr_tc_val = (state_q == ST_ON) ? TW'(SCAN_DIV - 1) : TW'(DEAD_CYCLES - 1);

    seg_scan_timer #(
        .W (TW)
    ) u_timer (
        .clk      (CLK),
        .rst      (RST),
        .clr      (tmr_clr),
        .en       (1'b1),
        .load     (1'b0),
        .load_val ('0),
        .tc_val   (tmr_tc_val),
        .tc       (tmr_tc)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            shadow_q     <= '0;
            pending_q    <= '0;
            pend_vld_q   <= 1'b0;
            nib_q        <= 4'h0;
            digit_q      <= DIGIT_OFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            pend_vld_q   <= pend_vld_d;
            nib_q        <= nib_d;
            digit_q      <= digit_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tmr_clr    = 1'b0;
        frame_wrap = 1'b0;
        xfer       = 1'b0;
        if (!ENABLE) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            tmr_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_DEAD;
                    idx_d   = '0;
                    tmr_clr = 1'b1;
                    xfer    = 1'b1;
                end
                ST_DEAD: begin
                    if (tmr_tc) begin
                        state_d = ST_ON;
                        tmr_clr = 1'b1;
                    end
                end
                ST_ON: begin
                    if (tmr_tc) begin
                        state_d = ST_DEAD;
                        tmr_clr = 1'b1;
                        if (idx_q == IDX_LAST) begin
                            idx_d      = '0;
                            frame_wrap = 1'b1;
                            xfer       = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    tmr_clr = 1'b1;
                end
            endcase
        end
    end

    // A LOAD on the transfer edge itself goes straight to shadow, skipping pending.
    always_comb begin
        pending_d  = pending_q;
        pend_vld_d = pend_vld_q;
        shadow_d   = shadow_q;
        if (LOAD) begin
            pending_d  = VALUE;
            pend_vld_d = 1'b1;
        end
        if (xfer) begin
            pend_vld_d = 1'b0;
            if (LOAD) begin
                shadow_d = VALUE;
            end else if (pend_vld_q) begin
                shadow_d = pending_q;
            end
        end
    end

`ifdef SEG_SCAN_LZB_EN
    always_comb begin
        lzb_blank = (idx_d != '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((IW'(i) >= idx_d) && (shadow_d[4*i +: 4] != 4'h0)) begin
                lzb_blank = 1'b0;
            end
        end
    end
`else
    assign lzb_blank = 1'b0;
`endif

    // Outputs are registered from next-state values so they line up with state_q.
    always_comb begin
        digit_d      = DIGIT_OFF;
        nib_d        = 4'h0;
        frame_done_d = frame_wrap;
        case (state_d)
            ST_DEAD: nib_d = shadow_d[{idx_d, 2'b00} +: 4];
            ST_ON: begin
                nib_d = nib_q;
                if (!lzb_blank) begin
                    digit_d[idx_d] = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign D          = nib_q;
    assign DIGIT      = digit_q;
    assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with NUM_DIGITS=4, SCAN_DIV=8, DEAD_CYCLES=2.
module tb_seg_scan_mux;

    logic        CLK;
    logic        RST;
    logic [15:0] VALUE;
    logic        LOAD;
    logic        ENABLE;
    logic [3:0]  D;
    logic [3:0]  DIGIT;
    logic        FRAME_DONE;

    int tests = 0;
    int fails = 0;

`ifdef SEG_SCAN_LZB_EN
    localparam logic [3:0] LIT_TWO = 4'b0011;
    localparam logic [3:0] LIT_ONE = 4'b0001;
`else
    localparam logic [3:0] LIT_TWO = 4'b1111;
    localparam logic [3:0] LIT_ONE = 4'b1111;
`endif

    seg_scan_mux #(
        .NUM_DIGITS  (4),
        .SCAN_DIV    (8),
        .DEAD_CYCLES (2)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .VALUE      (VALUE),
        .LOAD       (LOAD),
        .ENABLE     (ENABLE),
        .D          (D),
        .DIGIT      (DIGIT),
        .FRAME_DONE (FRAME_DONE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Walks one 40-cycle frame from its first dead cycle, optionally pulsing LOAD at two positions.
    task automatic check_frame(input string name, input logic [15:0] exp_val,
                               input logic [3:0] lit, input logic first_done,
                               input int lp1, input logic [15:0] lv1,
                               input int lp2, input logic [15:0] lv2);
        logic [3:0] exp_d;
        logic [3:0] exp_digit;
        logic       exp_done;
        for (int p = 0; p < 40; p++) begin
            int dg;
            int q;
            dg        = p / 10;
            q         = p % 10;
            exp_d     = exp_val[4*dg +: 4];
            exp_digit = 4'hF;
            if (q >= 2 && lit[dg]) exp_digit[dg] = 1'b0;
            exp_done  = (p == 0) ? first_done : 1'b0;
            tests++;
            if (D !== exp_d) begin
                fails++;
                $display("FAIL %s p=%0d D got %h want %h", name, p, D, exp_d);
            end
            tests++;
            if (DIGIT !== exp_digit) begin
                fails++;
                $display("FAIL %s p=%0d DIGIT got %b want %b", name, p, DIGIT, exp_digit);
            end
            tests++;
            if (FRAME_DONE !== exp_done) begin
                fails++;
                $display("FAIL %s p=%0d FRAME_DONE got %b want %b", name, p, FRAME_DONE, exp_done);
            end
            if (p == lp1) begin
                LOAD  = 1'b1;
                VALUE = lv1;
            end else if (p == lp2) begin
                LOAD  = 1'b1;
                VALUE = lv2;
            end else begin
                LOAD = 1'b0;
            end
            tick();
        end
        LOAD = 1'b0;
    endtask

    task automatic test_reset();
        LOAD   = 1'b0;
        ENABLE = 1'b0;
        VALUE  = 16'h0;
        RST    = 1'b0;
        #2;
        RST = 1'b1;
        repeat (3) tick();
        tests++;
        if (DIGIT !== 4'hF) begin fails++; $display("FAIL reset DIGIT got %b want 1111", DIGIT); end
        tests++;
        if (D !== 4'h0) begin fails++; $display("FAIL reset D got %h want 0", D); end
        tests++;
        if (FRAME_DONE !== 1'b0) begin fails++; $display("FAIL reset FRAME_DONE got %b want 0", FRAME_DONE); end
        RST = 1'b0;
        tick();
        tests++;
        if (DIGIT !== 4'hF) begin fails++; $display("FAIL idle DIGIT got %b want 1111", DIGIT); end
    endtask

    task automatic test_basic_scan();
        LOAD  = 1'b1;
        VALUE = 16'h1234;
        tick();
        LOAD   = 1'b0;
        ENABLE = 1'b1;
        tick();
        check_frame("basic0", 16'h1234, 4'hF, 1'b0, -1, 16'h0, -1, 16'h0);
        check_frame("basic1", 16'h1234, 4'hF, 1'b1, -1, 16'h0, -1, 16'h0);
    endtask

    task automatic test_mid_frame_load();
        check_frame("mid_cur", 16'h1234, 4'hF, 1'b1, 20, 16'h5555, 25, 16'hABCD);
        check_frame("mid_next", 16'hABCD, 4'hF, 1'b1, 39, 16'h00F0, -1, 16'h0);
    endtask

    task automatic test_wrap_load();
        check_frame("wrap_00F0", 16'h00F0, LIT_TWO, 1'b1, 39, 16'h0050, -1, 16'h0);
    endtask

    task automatic test_lzb();
        check_frame("lzb_0050", 16'h0050, LIT_TWO, 1'b1, 39, 16'h0000, -1, 16'h0);
        check_frame("lzb_0000", 16'h0000, LIT_ONE, 1'b1, 39, 16'h1234, -1, 16'h0);
    endtask

    task automatic test_enable_drop();
        repeat (13) tick();
        tests++;
        if (DIGIT !== 4'b1101) begin fails++; $display("FAIL drop_pre DIGIT got %b want 1101", DIGIT); end
        tests++;
        if (D !== 4'h3) begin fails++; $display("FAIL drop_pre D got %h want 3", D); end
        ENABLE = 1'b0;
        tick();
        tests++;
        if (DIGIT !== 4'hF) begin fails++; $display("FAIL drop DIGIT got %b want 1111", DIGIT); end
        tests++;
        if (D !== 4'h0) begin fails++; $display("FAIL drop D got %h want 0", D); end
        tests++;
        if (FRAME_DONE !== 1'b0) begin fails++; $display("FAIL drop FRAME_DONE got %b want 0", FRAME_DONE); end
        tick();
        ENABLE = 1'b1;
        tick();
        tests++;
        if (DIGIT !== 4'hF) begin fails++; $display("FAIL reen_dead0 DIGIT got %b want 1111", DIGIT); end
        tests++;
        if (D !== 4'h4) begin fails++; $display("FAIL reen_dead0 D got %h want 4", D); end
        tick();
        tests++;
        if (DIGIT !== 4'hF) begin fails++; $display("FAIL reen_dead1 DIGIT got %b want 1111", DIGIT); end
        tick();
        tests++;
        if (DIGIT !== 4'b1110) begin fails++; $display("FAIL reen_on DIGIT got %b want 1110", DIGIT); end
        tests++;
        if (D !== 4'h4) begin fails++; $display("FAIL reen_on D got %h want 4", D); end
    endtask

    task automatic test_async_reset();
        tick();
        #3;
        tests++;
        if (DIGIT !== 4'b1110) begin fails++; $display("FAIL arst_pre DIGIT got %b want 1110", DIGIT); end
        RST = 1'b1;
        #1;
        tests++;
        if (DIGIT !== 4'hF) begin fails++; $display("FAIL arst DIGIT got %b want 1111", DIGIT); end
        tests++;
        if (D !== 4'h0) begin fails++; $display("FAIL arst D got %h want 0", D); end
        tests++;
        if (FRAME_DONE !== 1'b0) begin fails++; $display("FAIL arst FRAME_DONE got %b want 0", FRAME_DONE); end
        #1;
        RST = 1'b0;
        tick();
        repeat (2) tick();
        tests++;
        if (D !== 4'h0) begin fails++; $display("FAIL arst_shadow D got %h want 0", D); end
        tests++;
        if (DIGIT !== 4'b1110) begin fails++; $display("FAIL arst_restart DIGIT got %b want 1110", DIGIT); end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_mid_frame_load();
        test_wrap_load();
        test_lzb();
        test_enable_drop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
